video_mem_sched: RTL and testbench

- Schedules one shared frame-buffer memory bus between two DMA channels.
- Channel IN writes camera words from the input FIFO into memory.
- Channel OUT reads words from memory into the output FIFO that feeds the video output generator.
- Manages double-buffered frame storage and issues fixed-length bursts, so a displayed frame never tears.

---
 rtl/video_mem_pkg.sv | 30 +++
 rtl/dma_addr_ctr.sv | 62 ++++++
 rtl/video_mem_sched.sv | 214 +++++++++++++++++++++
 tb/tb_video_mem_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/video_mem_pkg.sv
// Shared definitions for the video frame-buffer memory scheduler.
//   - sched_state_t : bus scheduler states
//   - BURST, FRAME_WORDS, CNT_W : default sizing
//   - BASE0, BASE1 : word addresses of the two frame buffers
//   - buf_base()   : maps a buffer select bit to its base address
package video_mem_pkg;

    localparam int unsigned BURST       = 16;
    localparam int unsigned FRAME_WORDS = 76800;
    localparam int unsigned CNT_W       = 8;
    localparam logic [31:0] BASE0       = 32'h0000_0000;
    localparam logic [31:0] BASE1       = 32'h0002_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } sched_state_t;

    function automatic logic [31:0] buf_base(input logic sel);
        logic [31:0] base;
        if (sel) begin
            base = BASE1;
        end else begin
            base = BASE0;
        end
        return base;
    endfunction

endpackage

// File: rtl/dma_addr_ctr.sv
// Word-offset counter for one DMA channel.
//   clk, nRST : clock, asynchronous active-low reset
//   clr       : restart the frame at offset 0 (wins over adv)
//   adv       : one word transferred (acked) this cycle
//   off       : current word offset inside the frame
//   wrap      : adv on the last word of the frame (offset returns to 0)
//   last      : adv on the last word of a burst
// Bursts always start on a BURST boundary, so the burst-last flag is just
// the low offset bits being all ones.
module dma_addr_ctr #(
    parameter int unsigned FRAME_WORDS = 76800,
    parameter int unsigned BURST       = 16,
    parameter int unsigned OFF_W       = $clog2(FRAME_WORDS)
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             clr,
    input  logic             adv,
    output logic [OFF_W-1:0] off,
    output logic             wrap,
    output logic             last
);

    localparam int unsigned LB = $clog2(BURST);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(FRAME_WORDS - 1);

    logic [OFF_W-1:0] off_q;
    logic [OFF_W-1:0] off_d;
    logic             at_end_s;

    assign at_end_s = (off_q == OFF_LAST);

    // Next offset: clear, advance with wrap, or hold.
    always_comb begin
        off_d = off_q;
        if (clr) begin
            off_d = '0;
        end else if (adv) begin
            if (at_end_s) begin
                off_d = '0;
            end else begin
                off_d = off_q + {{(OFF_W-1){1'b0}}, 1'b1};
            end
        end else begin
            off_d = off_q;
        end
    end

    // Offset register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign off  = off_q;
    assign wrap = adv && !clr && at_end_s;
    assign last = adv && !clr && (&off_q[LB-1:0]);

endmodule

// File: rtl/video_mem_sched.sv
// Double-buffered frame-buffer bus scheduler for a camera-in / video-out pipe.
//   clk, nRST       : clock, asynchronous active-low reset
//   in_sof          : camera start-of-frame pulse
//   in_fifo_count   : words waiting in the input FIFO
//   in_fifo_rd      : input FIFO pop (= m_ack during a write burst)
//   out_fifo_space  : free words in the output FIFO
//   out_fifo_wr     : output FIFO push (= m_ack during a read burst)
//   m_cyc/m_stb/m_we/m_adr/m_ack : memory bus, fixed-length bursts
//   rd_buf          : buffer currently displayed
//   frame_drop      : pulse when an incomplete IN frame is abandoned
module video_mem_sched #(
    parameter int unsigned BURST       = video_mem_pkg::BURST,
    parameter int unsigned FRAME_WORDS = video_mem_pkg::FRAME_WORDS,
    parameter int unsigned CNT_W       = video_mem_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             in_sof,
    input  logic [CNT_W-1:0] in_fifo_count,
    output logic             in_fifo_rd,
    input  logic [CNT_W-1:0] out_fifo_space,
    output logic             out_fifo_wr,
    output logic             m_cyc,
    output logic             m_stb,
    output logic             m_we,
    output logic [31:0]      m_adr,
    input  logic             m_ack,
    output logic             rd_buf,
    output logic             frame_drop
);

    import video_mem_pkg::*;

    localparam int unsigned OFF_W = $clog2(FRAME_WORDS);
    localparam logic [CNT_W-1:0] BURST_LVL = CNT_W'(BURST);

    sched_state_t state_q, state_d;
    logic rd_buf_q, rd_buf_d;
    logic wr_buf_q, wr_buf_d;
    logic done_valid_q, done_valid_d;
    logic have_frame_q, have_frame_d;
    logic wr_active_q, wr_active_d;
    logic last_out_q, last_out_d;       // 1: OUT had the last grant
    logic sof_pend_q, sof_pend_d;       // in_sof seen during a write burst
    logic rd_new_frame_q, rd_new_frame_d;
    logic frame_drop_q, frame_drop_d;

    logic             rd_elig_s, wr_elig_s, sof_apply_s, wr_clr_s;
    logic             rd_adv_s, wr_adv_s;
    logic [OFF_W-1:0] rd_off_s, wr_off_s;
    logic             rd_wrap_s, rd_last_s, wr_wrap_s, wr_last_s;

    assign rd_adv_s = (state_q == RD_BURST) && m_ack;
    assign wr_adv_s = (state_q == WR_BURST) && m_ack;

    dma_addr_ctr #(.FRAME_WORDS(FRAME_WORDS), .BURST(BURST), .OFF_W(OFF_W)) u_rd_ctr (
        .clk(clk), .nRST(nRST), .clr(1'b0), .adv(rd_adv_s),
        .off(rd_off_s), .wrap(rd_wrap_s), .last(rd_last_s)
    );

    dma_addr_ctr #(.FRAME_WORDS(FRAME_WORDS), .BURST(BURST), .OFF_W(OFF_W)) u_wr_ctr (
        .clk(clk), .nRST(nRST), .clr(wr_clr_s), .adv(wr_adv_s),
        .off(wr_off_s), .wrap(wr_wrap_s), .last(wr_last_s)
    );

    assign rd_elig_s = have_frame_q && (out_fifo_space >= BURST_LVL);
    assign wr_elig_s = wr_active_q && (in_fifo_count >= BURST_LVL);

    // Scheduler next state, buffer ownership and writer/reader frame control.
    always_comb begin
        state_d        = state_q;
        rd_buf_d       = rd_buf_q;
        wr_buf_d       = wr_buf_q;
        done_valid_d   = done_valid_q;
        have_frame_d   = have_frame_q;
        wr_active_d    = wr_active_q;
        last_out_d     = last_out_q;
        sof_pend_d     = sof_pend_q;
        rd_new_frame_d = rd_new_frame_q;
        frame_drop_d   = 1'b0;
        sof_apply_s    = 1'b0;
        wr_clr_s       = 1'b0;

        case (state_q)
            IDLE: begin
                sof_apply_s = in_sof || sof_pend_q;
                sof_pend_d  = 1'b0;
                // OUT wins unless IN is also eligible and OUT had the last turn.
                if (rd_elig_s && (!wr_elig_s || !last_out_q)) begin
                    state_d        = RD_BURST;
                    last_out_d     = 1'b1;
                    rd_new_frame_d = 1'b0;
                    if (rd_new_frame_q && done_valid_q) begin
                        rd_buf_d     = wr_buf_q;
                        done_valid_d = 1'b0;
                        have_frame_d = 1'b1;
                    end else begin
                        rd_buf_d = rd_buf_q;
                    end
                end else if (wr_elig_s) begin
                    state_d    = WR_BURST;
                    last_out_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_BURST: begin
                sof_apply_s = in_sof;
                if (rd_wrap_s) begin
                    rd_new_frame_d = 1'b1;
                end else begin
                    rd_new_frame_d = rd_new_frame_q;
                end
                if (rd_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                // The write counter is busy; defer the restart to IDLE.
                if (in_sof) begin
                    sof_pend_d = 1'b1;
                end else begin
                    sof_pend_d = sof_pend_q;
                end
                if (wr_wrap_s) begin
                    done_valid_d = 1'b1;
                    wr_active_d  = 1'b0;
                    have_frame_d = 1'b1;
                end else begin
                    done_valid_d = done_valid_q;
                end
                if (wr_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Start-of-frame is applied last so it overrides a same-cycle wrap,
        // and targets the buffer opposite the one the reader will show next.
        if (sof_apply_s) begin
            frame_drop_d = (wr_off_s != '0);
            wr_buf_d     = ~rd_buf_d;
            wr_clr_s     = 1'b1;
            done_valid_d = 1'b0;
            wr_active_d  = 1'b1;
        end else begin
            wr_clr_s = 1'b0;
        end
    end

    // Scheduler and frame-control registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            rd_buf_q       <= 1'b0;
            wr_buf_q       <= 1'b1;
            done_valid_q   <= 1'b0;
            have_frame_q   <= 1'b0;
            wr_active_q    <= 1'b0;
            last_out_q     <= 1'b0;
            sof_pend_q     <= 1'b0;
            rd_new_frame_q <= 1'b1;
            frame_drop_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_buf_q       <= rd_buf_d;
            wr_buf_q       <= wr_buf_d;
            done_valid_q   <= done_valid_d;
            have_frame_q   <= have_frame_d;
            wr_active_q    <= wr_active_d;
            last_out_q     <= last_out_d;
            sof_pend_q     <= sof_pend_d;
            rd_new_frame_q <= rd_new_frame_d;
            frame_drop_q   <= frame_drop_d;
        end
    end

    // Bus outputs follow the state register directly.
    always_comb begin
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
        m_adr = 32'h0000_0000;
        case (state_q)
            RD_BURST: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                m_adr = buf_base(rd_buf_q) + 32'(rd_off_s);
            end
            WR_BURST: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                m_we  = 1'b1;
                m_adr = buf_base(wr_buf_q) + 32'(wr_off_s);
            end
            default: begin
                m_adr = 32'h0000_0000;
            end
        endcase
    end

    assign in_fifo_rd  = wr_adv_s;
    assign out_fifo_wr = rd_adv_s;
    assign rd_buf      = rd_buf_q;
    assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_video_mem_sched.sv
// Directed bench for video_mem_sched with a 64-word frame (4 bursts of 16).
module tb_video_mem_sched;

    localparam int unsigned BURST = 16;
    localparam int unsigned FW    = 64;
    localparam int unsigned CW    = 8;

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          in_sof = 1'b0;
    logic [CW-1:0] in_fifo_count = 8'd0;
    logic          in_fifo_rd;
    logic [CW-1:0] out_fifo_space = 8'd0;
    logic          out_fifo_wr;
    logic          m_cyc, m_stb, m_we;
    logic [31:0]   m_adr;
    logic          m_ack = 1'b0;
    logic          rd_buf;
    logic          frame_drop;

    int tests_run = 0;
    int tests_failed = 0;

    video_mem_sched #(.BURST(BURST), .FRAME_WORDS(FW), .CNT_W(CW)) dut (
        .clk(clk), .nRST(nRST), .in_sof(in_sof),
        .in_fifo_count(in_fifo_count), .in_fifo_rd(in_fifo_rd),
        .out_fifo_space(out_fifo_space), .out_fifo_wr(out_fifo_wr),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_ack(m_ack), .rd_buf(rd_buf), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_stb();
        int n;
        n = 0;
        while (m_stb !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("stb_wait", {31'd0, m_stb}, 32'd1);
    endtask

    task automatic pulse_sof();
        in_sof = 1'b1;
        @(posedge clk); #1;
        in_sof = 1'b0;
    endtask

    // Serve one burst; ack word i after a random stall of up to max_wait cycles.
    task automatic do_burst(input logic we, input logic [31:0] start,
                            input int max_wait, input logic [31:0] mask);
        int w;
        logic [31:0] exp_adr;
        wait_stb();
        check("m_we", {31'd0, m_we}, {31'd0, we});
        for (int i = 0; i < BURST; i++) begin
            exp_adr = (start + 32'(i)) & mask;
            w = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
            for (int k = 0; k < w; k++) begin
                @(posedge clk); #1;
                check("adr_stall", m_adr & mask, exp_adr);
            end
            check("m_adr", m_adr & mask, exp_adr);
            m_ack = 1'b1;
            #1;
            if (we) begin
                check("in_fifo_rd", {31'd0, in_fifo_rd}, 32'd1);
                check("out_fifo_wr_quiet", {31'd0, out_fifo_wr}, 32'd0);
            end else begin
                check("out_fifo_wr", {31'd0, out_fifo_wr}, 32'd1);
                check("in_fifo_rd_quiet", {31'd0, in_fifo_rd}, 32'd0);
            end
            @(posedge clk); #1;
            m_ack = 1'b0;
        end
        check("idle_after_burst", {31'd0, m_stb}, 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", {31'd0, m_cyc}, 32'd0);
        check("rst_stb", {31'd0, m_stb}, 32'd0);
        check("rst_we", {31'd0, m_we}, 32'd0);
        check("rst_adr", m_adr, 32'd0);
        check("rst_rd_buf", {31'd0, rd_buf}, 32'd0);
        check("rst_drop", {31'd0, frame_drop}, 32'd0);
        nRST = 1'b1;

        // No in_sof yet: a full input FIFO must not start any write.
        in_fifo_count = 8'd16;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            check("idle_outs", {26'd0, m_cyc, m_stb, m_we, in_fifo_rd, out_fifo_wr, frame_drop}, 32'd0);
        end

        // First frame is written into buffer 1; nothing is read meanwhile.
        pulse_sof();
        check("sof1_drop", {31'd0, frame_drop}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            do_burst(1'b1, 32'h0002_0000 + 32'(16 * k), 0, 32'hFFFF_FFFF);
        end

        // Frame complete: reader switches to buffer 1.
        out_fifo_space = 8'd64;
        do_burst(1'b0, 32'h0002_0000, 0, 32'hFFFF_FFFF);
        check("rd_buf_after_swap", {31'd0, rd_buf}, 32'd1);

        // New frame goes to buffer 0; grants alternate RD/WR with stalls.
        pulse_sof();
        check("sof2_drop", {31'd0, frame_drop}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            do_burst(1'b0, 32'h0002_0000 + 32'(16 * k), 3, 32'hFFFF_FFFF);
            do_burst(1'b1, 32'(16 * (k - 1)), 3, 32'hFFFF_FFFF);
        end

        // 48 words written, restart: one drop pulse, writer back to offset 0,
        // reader repeats buffer 1 until the new frame completes.
        pulse_sof();
        check("drop_pulse", {31'd0, frame_drop}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            do_burst(1'b0, 32'h0002_0000 + 32'(16 * k), 2, 32'hFFFF_FFFF);
            if (k == 0) begin
                check("drop_one_cycle", {31'd0, frame_drop}, 32'd0);
                check("rd_buf_kept", {31'd0, rd_buf}, 32'd1);
            end
            do_burst(1'b1, 32'(16 * k), 2, 32'hFFFF_FFFF);
        end

        // Rewritten frame done: next read frame comes from buffer 0.
        wait_stb();
        check("swap0_we", {31'd0, m_we}, 32'd0);
        check("swap0_adr", m_adr, 32'h0000_0000);
        check("swap0_rd_buf", {31'd0, rd_buf}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("part_adr", m_adr, 32'(i));
            m_ack = 1'b1;
            @(posedge clk); #1;
            m_ack = 1'b0;
        end

        // Reset mid-burst drops the bus without waiting for a clock edge.
        #2;
        nRST = 1'b0;
        #1;
        check("async_cyc", {31'd0, m_cyc}, 32'd0);
        check("async_stb", {31'd0, m_stb}, 32'd0);
        @(posedge clk); #1;
        nRST = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {31'd0, m_stb}, 32'd0);
        end
        pulse_sof();
        for (int k = 0; k < 4; k++) begin
            do_burst(1'b1, 32'h0002_0000 + 32'(16 * k), 0, 32'hFFFF_FFFF);
        end
        do_burst(1'b0, 32'h0000_0000, 0, 32'h0001_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
